// File: rtl/mvm_stream_skid_fifo.sv
// Elastic LANES x WIDTH ready/valid FIFO between the operand path and the MVM core; optional SKID_BYPASS_EN.
// Latency: 1 cycle from push to head (0 cycles through the bypass when empty and SKID_BYPASS_EN is defined).
// Backpressure: in_ready comes only from registered state and drops at count==DEPTH; flush empties synchronously.
module mvm_stream_skid_fifo #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [LANES*WIDTH-1:0]     in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [LANES*WIDTH-1:0]     out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int DW = LANES * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          rst_done;
    logic          stored_vld;
    logic          push;
    logic          store;
    logic          pop_mem;

    assign stored_vld  = (cnt != '0);
    assign in_ready    = rst_done && (cnt != FULL_CNT);
    assign push        = in_valid && in_ready;
    assign pop_mem     = stored_vld && out_ready;
    assign count       = cnt;
    assign almost_full = (cnt >= AF_CNT);

`ifdef SKID_BYPASS_EN
    logic bypass_vld;
    logic bypass;

    // When empty the incoming word is presented straight to the output; it is
    // written to storage only if downstream does not take it this cycle.
    assign bypass_vld = !stored_vld && in_valid && rst_done && !flush;
    assign bypass     = bypass_vld && out_ready;
    assign store      = push && !bypass;
    assign out_valid  = stored_vld || bypass_vld;
    assign out_data   = stored_vld ? mem[rd_ptr] : (bypass_vld ? in_data : '0);
`else
    assign store      = push;
    assign out_valid  = stored_vld;
    assign out_data   = stored_vld ? mem[rd_ptr] : '0;
`endif

    // Storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (store && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_done <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            rst_done <= 1'b1;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (store) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_mem) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({store, pop_mem})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end
endmodule

// File: doc/mvm_stream_skid_fifo.md
Name: mvm_stream_skid_fifo

Overview:
- Parametrised elastic ready/valid buffer between the Wishbone-fed operand path and the matrix-vector core.
- Next generation of the single-entry skid buffer: multi-lane packed data (LANES x WIDTH, e.g. one vector row), configurable depth, occupancy/almost-full reporting, synchronous flush.
- in_ready is derived only from registered state, never combinationally from out_ready, so it breaks the upstream ready timing path.

Parameters:
- WIDTH, 8, bits per lane (signed element width).
- LANES, 8, lanes per word; data bus width is LANES*WIDTH.
- DEPTH, 4, storage entries; power of two, >= 2.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH; 1 <= AF_THRESH <= DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all stored words.
- in_valid  in  1  upstream word valid.
- in_data  in  LANES*WIDTH  upstream word; lane i at bits [i*WIDTH +: WIDTH].
- in_ready  out  1  buffer accepts a word this cycle.
- out_valid  out  1  head word valid.
- out_data  out  LANES*WIDTH  head word.
- out_ready  in  1  downstream accepts the head word.
- count  out  $clog2(DEPTH+1)  stored word count.
- almost_full  out  1  count >= AF_THRESH.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rstn).
- Reset values:
  - count=0, rd_ptr=0, wr_ptr=0.
  - out_valid=0, out_data=0, almost_full=0.
  - in_ready=0 while rstn is low.
  - Internal rst_done flop sets on the first rising edge after rstn deasserts. From then on, in_ready = rst_done && (count != DEPTH).
- Handshake:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Upstream must hold in_valid/in_data stable until accepted. The block does not check this.
- Storage: DEPTH x (LANES*WIDTH) register array, not reset. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: mem[wr_ptr] <= in_data, then wr_ptr increments.
- Pop: rd_ptr increments.
- Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Output:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid is 1, else 0.
  - Lanes pass through bit-exact; no arithmetic or sign handling.
- Latency: a word pushed at edge N is on out_data with out_valid=1 in the cycle after edge N (1 cycle minimum).
- Throughput: 1 word/cycle sustained with simultaneous push and pop at any 0 < count < DEPTH.
- Boundary conditions:
  - Full (count==DEPTH): in_ready=0. A pop that cycle frees a slot, but in_ready rises only in the next cycle.
  - Empty (count==0): out_valid=0 and pop is impossible; out_ready is ignored.
  - Simultaneous push and pop at count==1: count stays 1 and the head advances to the new word.
- Flush: highest priority. At the edge where flush=1, count, rd_ptr and wr_ptr go to 0. Any push or pop in that cycle is discarded (the upstream handshake still completes and the word is dropped). in_ready is unaffected by flush.
- Reset mid-operation: all words lost immediately (asynchronous). out_valid falls without waiting for the clock.
- almost_full is combinational from registered count.

Optional Feature:
- Macro: SKID_BYPASS_EN.
- Defined: when count==0, out_valid = in_valid && rst_done and out_data = in_data combinationally.
  - If out_ready=1 in that cycle, the word passes with 0-cycle latency and is not written to storage; count and wr_ptr are unchanged.
  - If out_ready=0, the word is stored normally and appears from storage next cycle.
  - Bypass never occurs while flush=1 (flush drops the word).
- Undefined: no combinational path from in_* to out_*; minimum latency is 1 cycle as above.

Test Plan:
- Reset release: hold rstn=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0, out_data=0; in_ready=1 one edge after rstn rises.
- Fill/drain: out_ready=0; push 0x0102030405060708 .. +3 (DEPTH=4) -> count steps 1..4, almost_full from count=3, in_ready=0 at 4. Then out_ready=1 -> same 4 words drained in order, count returns to 0.
- Streaming: in_valid=1 and out_ready=1 continuously for 20 words with incrementing data -> one word out per cycle after the first-word latency, no loss or duplication, count stays 1 (bypass build: 0).
- Full plus simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop occurs, no push that cycle, count=3; push accepted next cycle, count back to 4 if out_ready=0.
- Flush: count=3, pulse flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the in-flight word is not stored; subsequent push 0xAA..AA appears as the head.
- Async reset mid-stream: count=2 and rstn falls between edges -> out_valid and count go to 0 immediately; after release the buffer restarts empty with in_ready=1 one edge later.
